// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and helpers for the forwarding/hazard unit
package hazard_pkg;

    // Tags are stored at a fixed width; narrower register addresses are zero-extended.
    localparam int MAX_REG_AW = 8;

    // Select value meaning "read the register file".
    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] rd;
        logic                  load;
    } tag_entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - issue-side bus of the forwarding/hazard unit
interface fwd_hazard_unit_if #(
    parameter int  REG_AW  = 5,
    parameter int  NUM_SRC = 2,
    parameter int  DEPTH   = 2,
    localparam int SELW    = hazard_pkg::sel_width(DEPTH)
);
    logic                      issue_valid;
    logic [REG_AW-1:0]         issue_rd;
    logic                      issue_regwrite;
    logic                      issue_is_load;
    logic [NUM_SRC*REG_AW-1:0] issue_rs;
    logic                      pipe_advance;
    logic                      flush;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall;
    logic [15:0]               stall_count;

    modport master (
        output issue_valid, issue_rd, issue_regwrite, issue_is_load, issue_rs,
        output pipe_advance, flush,
        input  fwd_sel, stall, stall_count
    );

    modport slave (
        input  issue_valid, issue_rd, issue_regwrite, issue_is_load, issue_rs,
        input  pipe_advance, flush,
        output fwd_sel, stall, stall_count
    );
endinterface

// File: rtl/fwd_tag_pipe.sv
// rtl/fwd_tag_pipe.sv - shadow shift register of in-flight destination tags
module fwd_tag_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   advance,
    input  logic                   flush,
    input  tag_entry_t             in_entry,
    output tag_entry_t [DEPTH-1:0] stages
);

    // Index 0 is stage 1 (EX/MEM); a flush empties stage 1 before it moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else if (advance) begin
            stages[0] <= flush ? '0 : in_entry;
            for (int k = 1; k < DEPTH; k++) begin
                stages[k] <= (k == 1 && flush) ? '0 : stages[k-1];
            end
        end else if (flush) begin
            stages[0] <= '0;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - per-source bypass selects, load-use stall and stall counter
module fwd_hazard_unit
    import hazard_pkg::*;
#(
    parameter int  REG_AW     = 5,
    parameter int  NUM_SRC    = 2,
    parameter int  DEPTH      = 2,
    parameter int  LOAD_READY = 2,
    localparam int SELW       = sel_width(DEPTH)
) (
    input logic               clk,
    input logic               reset,
    fwd_hazard_unit_if.slave  bus
);

    tag_entry_t [DEPTH-1:0]  stages;
    tag_entry_t              in_entry;
    logic                    accept;
    logic                    stall;
    logic [NUM_SRC-1:0]      hazard;
    logic [NUM_SRC*SELW-1:0] sel_all;
    logic [15:0]             stall_cnt;

    assign accept   = bus.issue_valid & bus.pipe_advance & ~stall & ~bus.flush;
    assign in_entry = '{valid: accept & bus.issue_regwrite & (bus.issue_rd != '0),
                        rd:    MAX_REG_AW'(bus.issue_rd),
                        load:  bus.issue_is_load};

    fwd_tag_pipe #(.DEPTH(DEPTH)) u_tags (
        .clk      (clk),
        .reset    (reset),
        .advance  (bus.pipe_advance),
        .flush    (bus.flush),
        .in_entry (in_entry),
        .stages   (stages)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [MAX_REG_AW-1:0] rs;
        logic [SELW-1:0]       sel_match;
        logic                  hit;
        logic                  hit_load;

        assign rs = MAX_REG_AW'(bus.issue_rs[i*REG_AW +: REG_AW]);

        // Scan oldest to youngest so the youngest live match is the one left standing.
        always_comb begin
            sel_match = SELW'(FWD_RF);
            hit       = 1'b0;
            hit_load  = 1'b0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (stages[k].valid && (stages[k].rd == rs) && (rs != '0)) begin
                    sel_match = SELW'(k + 1);
                    hit       = 1'b1;
                    hit_load  = stages[k].load;
                end
            end
        end

        assign hazard[i] = hit & hit_load & (int'(sel_match) < LOAD_READY);
        assign sel_all[i*SELW +: SELW] = hazard[i] ? SELW'(FWD_RF) : sel_match;
    end

    assign stall           = |hazard;
    assign bus.stall       = stall;
    assign bus.fwd_sel     = sel_all;
    assign bus.stall_count = stall_cnt;

    // Count stalled edges, including frozen ones, and stick at the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - scoreboard bench for default and wide configurations
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .DEPTH(2)) ifa ();
    fwd_hazard_unit_if #(.REG_AW(5), .NUM_SRC(3), .DEPTH(4)) ifb ();

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .DEPTH(2), .LOAD_READY(2)) u_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa)
    );

    fwd_hazard_unit #(.REG_AW(5), .NUM_SRC(3), .DEPTH(4), .LOAD_READY(3)) u_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb)
    );

    typedef struct {
        string       tag;
        int          dut;
        logic [11:0] sel;
        logic        stall;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            if (cur.dut == 0) begin
                check_eq({cur.tag, ".sel"},   32'(ifa.fwd_sel),     32'(cur.sel));
                check_eq({cur.tag, ".stall"}, 32'(ifa.stall),       32'(cur.stall));
                check_eq({cur.tag, ".cnt"},   32'(ifa.stall_count), 32'(cur.cnt));
            end else begin
                check_eq({cur.tag, ".sel"},   32'(ifb.fwd_sel),     32'(cur.sel));
                check_eq({cur.tag, ".stall"}, 32'(ifb.stall),       32'(cur.stall));
                check_eq({cur.tag, ".cnt"},   32'(ifb.stall_count), 32'(cur.cnt));
            end
        end
    end

    task automatic drv_a(input string tag, input logic rst, input logic v, input int rd,
                         input logic rw, input logic ld, input int rs1, input int rs2,
                         input logic adv, input logic fl, input int e1, input int e2,
                         input logic est, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_a              = rst;
        ifa.issue_valid    = v;
        ifa.issue_rd       = 5'(rd);
        ifa.issue_regwrite = rw;
        ifa.issue_is_load  = ld;
        ifa.issue_rs       = {5'(rs2), 5'(rs1)};
        ifa.pipe_advance   = adv;
        ifa.flush          = fl;
        e.tag   = tag;
        e.dut   = 0;
        e.sel   = 12'({2'(e2), 2'(e1)});
        e.stall = est;
        e.cnt   = 16'(ecnt);
        sb.push_back(e);
    endtask

    task automatic drv_b(input string tag, input logic rst, input logic v, input int rd,
                         input logic rw, input logic ld, input int rs1, input int rs2,
                         input int rs3, input logic adv, input logic fl, input int e1,
                         input int e2, input int e3, input logic est, input int ecnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst_b              = rst;
        ifb.issue_valid    = v;
        ifb.issue_rd       = 5'(rd);
        ifb.issue_regwrite = rw;
        ifb.issue_is_load  = ld;
        ifb.issue_rs       = {5'(rs3), 5'(rs2), 5'(rs1)};
        ifb.pipe_advance   = adv;
        ifb.flush          = fl;
        e.tag   = tag;
        e.dut   = 1;
        e.sel   = 12'({3'(e3), 3'(e2), 3'(e1)});
        e.stall = est;
        e.cnt   = 16'(ecnt);
        sb.push_back(e);
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.issue_valid = 1'b0; ifa.issue_rd = '0; ifa.issue_regwrite = 1'b0;
        ifa.issue_is_load = 1'b0; ifa.issue_rs = '0; ifa.pipe_advance = 1'b1; ifa.flush = 1'b0;
        ifb.issue_valid = 1'b0; ifb.issue_rd = '0; ifb.issue_regwrite = 1'b0;
        ifb.issue_is_load = 1'b0; ifb.issue_rs = '0; ifb.pipe_advance = 1'b1; ifb.flush = 1'b0;
        repeat (2) @(posedge clk);

        //     tag          rst v  rd rw ld rs1 rs2 adv fl  e1 e2 st cnt
        drv_a("rst",         0, 1, 5, 1, 0, 0,  0,  1, 0,  0, 0, 0, 0);
        drv_a("fwd_s1",      0, 1, 8, 1, 0, 5,  6,  1, 0,  1, 0, 0, 0);
        drv_a("fwd_s2",      0, 1, 5, 1, 0, 5,  0,  1, 0,  2, 0, 0, 0);
        drv_a("mix",         0, 1, 5, 1, 0, 5,  8,  1, 0,  1, 2, 0, 0);
        drv_a("youngest",    0, 1, 0, 1, 0, 5,  5,  1, 0,  1, 1, 0, 0);
        drv_a("x0",          0, 1, 7, 0, 0, 0,  5,  1, 0,  0, 2, 0, 0);
        drv_a("nowrite",     0, 1, 7, 1, 1, 7,  0,  1, 0,  0, 0, 0, 0);
        drv_a("lu_stall",    0, 1, 10, 1, 0, 7, 0,  1, 0,  0, 0, 1, 0);
        drv_a("lu_fwd",      0, 1, 10, 1, 0, 7, 0,  1, 0,  2, 0, 0, 1);
        drv_a("bubble",      0, 1, 11, 1, 1, 7, 0,  1, 0,  0, 0, 0, 1);
        drv_a("frz0",        0, 1, 12, 0, 0, 11, 0, 0, 0,  0, 0, 1, 1);
        drv_a("frz1",        0, 1, 12, 0, 0, 11, 0, 0, 0,  0, 0, 1, 2);
        drv_a("frz2",        0, 1, 12, 0, 0, 11, 0, 0, 0,  0, 0, 1, 3);
        drv_a("release",     0, 1, 12, 0, 0, 11, 0, 1, 0,  0, 0, 1, 4);
        drv_a("resume",      0, 1, 9, 1, 0, 11, 0,  1, 0,  2, 0, 0, 5);
        drv_a("fl_pre",      0, 1, 13, 1, 0, 9, 0,  1, 1,  1, 0, 0, 5);
        drv_a("fl_st1",      0, 0, 0, 0, 0, 9,  13, 1, 0,  0, 0, 0, 5);
        drv_a("fl_st2",      0, 1, 14, 1, 0, 9, 13, 1, 0,  0, 0, 0, 5);
        drv_a("frzfl",       0, 0, 0, 0, 0, 14, 0,  0, 1,  1, 0, 0, 5);
        drv_a("frzfl_chk",   0, 0, 0, 0, 0, 14, 0,  1, 0,  0, 0, 0, 5);

        //     tag          rst v  rd rw ld rs1 rs2 rs3 adv fl  e1 e2 e3 st cnt
        drv_b("b_rst",       0, 1, 3, 1, 1, 0,  0,  0,  1, 0,  0, 0, 0, 0, 0);
        drv_b("b_stall1",    0, 1, 4, 1, 0, 3,  0,  0,  1, 0,  0, 0, 0, 1, 0);
        drv_b("b_stall2",    0, 1, 4, 1, 0, 3,  0,  0,  1, 0,  0, 0, 0, 1, 1);
        drv_b("b_fwd3",      0, 1, 4, 1, 0, 3,  0,  0,  1, 0,  3, 0, 0, 0, 2);
        drv_b("b_fwd4",      0, 1, 20, 1, 1, 0, 3,  4,  1, 0,  0, 4, 1, 0, 2);
        drv_b("b_mixhaz",    0, 1, 21, 1, 0, 20, 4, 0,  1, 0,  0, 2, 0, 1, 2);
        drv_b("b_rst_mid",   1, 0, 0, 0, 0, 20, 4,  0,  1, 0,  0, 3, 0, 1, 3);
        drv_b("b_post_rst",  0, 0, 0, 0, 0, 20, 4,  3,  1, 0,  0, 0, 0, 0, 0);
        drv_b("b_post2",     0, 0, 0, 0, 0, 20, 4,  3,  1, 0,  0, 0, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
